// File: rtl/fir_tdm_pkg.sv
// rtl/fir_tdm_pkg.sv - shared types, default coefficient table and width helper for the TDM FIR
package fir_tdm_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MAC  = 1'b1
  } state_t;

  localparam int COEF_DEFAULT_LEN = 16;

  // Symmetric low-pass taps, DC gain 280
  localparam logic signed [7:0] COEF_DEFAULT [COEF_DEFAULT_LEN] = '{
    -8'sd2,  -8'sd3,  -8'sd1,  8'sd5,  8'sd16, 8'sd30, 8'sd43, 8'sd52,
    8'sd52,  8'sd43,  8'sd30,  8'sd16, 8'sd5,  -8'sd1, -8'sd3, -8'sd2
  };

  function automatic int acc_width(input int taps, input int dw, input int cw);
    return dw + cw + $clog2(taps);
  endfunction

  // Tables longer than the default repeat it
  function automatic logic signed [7:0] coef_default(input int k);
    return COEF_DEFAULT[4'(k)];
  endfunction

endpackage

// File: rtl/fir_tdm_ctrl_if.sv
// rtl/fir_tdm_ctrl_if.sv - sample/result/coefficient bus of fir_tdm_ctrl
// Coefficient write signals exist only with FIR_TDM_COEF_WR_EN.
interface fir_tdm_ctrl_if #(
  parameter int TAPS = 16,
  parameter int DW   = 4,
  parameter int CW   = 8,
  parameter int ACCW = fir_tdm_pkg::acc_width(TAPS, DW, CW)
);
  localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;

  logic                   in_valid;
  logic                   in_ready;
  logic [DW-1:0]          in_data;
  logic                   out_valid;
  logic signed [ACCW-1:0] out_data;
  logic                   busy;
`ifdef FIR_TDM_COEF_WR_EN
  logic                   coef_we;
  logic [AW-1:0]          coef_addr;
  logic signed [CW-1:0]   coef_wdata;
`endif

`ifdef FIR_TDM_COEF_WR_EN
  modport master (
    output in_valid, in_data, coef_we, coef_addr, coef_wdata,
    input  in_ready, out_valid, out_data, busy
  );
  modport slave (
    input  in_valid, in_data, coef_we, coef_addr, coef_wdata,
    output in_ready, out_valid, out_data, busy
  );
`else
  modport master (
    output in_valid, in_data,
    input  in_ready, out_valid, out_data, busy
  );
  modport slave (
    input  in_valid, in_data,
    output in_ready, out_valid, out_data, busy
  );
`endif

endinterface

// File: rtl/fir_tdm_mac.sv
// rtl/fir_tdm_mac.sv - shared signed multiplier with full-precision accumulator
module fir_tdm_mac #(
  parameter int DW   = 4,
  parameter int CW   = 8,
  parameter int ACCW = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   en,
  input  logic signed [DW-1:0]   sample,
  input  logic signed [CW-1:0]   coef,
  output logic signed [ACCW-1:0] sum
);

  logic signed [DW+CW-1:0] product;
  logic signed [ACCW-1:0]  acc;

  assign product = (DW+CW)'(sample) * (DW+CW)'(coef);
  assign sum     = acc + ACCW'(product);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/fir_tdm_ctrl.sv
// rtl/fir_tdm_ctrl.sv - TDM FIR sequencer: ring buffer, tap walk, one MAC per clock
// FIR_TDM_COEF_WR_EN adds writable coefficient registers; otherwise taps are constants.
module fir_tdm_ctrl
  import fir_tdm_pkg::*;
#(
  parameter int TAPS = 16,
  parameter int DW   = 4,
  parameter int CW   = 8,
  parameter int ACCW = acc_width(TAPS, DW, CW)
) (
  input  logic           clk,
  input  logic           rst_n,
  fir_tdm_ctrl_if.slave  bus
);

  localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;

  state_t                 state;
  state_t                 state_next;
  logic                   in_ready;
  logic                   busy;
  logic                   accept;
  logic                   last;
  logic [AW-1:0]          head;
  logic [AW-1:0]          head_new;
  logic [AW-1:0]          k;
  logic [AW-1:0]          rd_idx;
  logic signed [DW-1:0]   ring [TAPS];
  logic signed [DW-1:0]   x;
  logic signed [DW-1:0]   sample;
  logic signed [CW-1:0]   coef_rd;
  logic signed [ACCW-1:0] sum;
  logic                   out_valid;
  logic signed [ACCW-1:0] out_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_next = MAC;
      end
      MAC: begin
        busy = 1'b1;
        if (k == AW'(TAPS - 1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept   = in_ready && bus.in_valid;
  assign last     = busy && (k == AW'(TAPS - 1));
  assign head_new = (head == AW'(TAPS - 1)) ? '0 : head + AW'(1);

  // Offset-binary to two's complement is an MSB flip
  assign x = {~bus.in_data[DW-1], bus.in_data[DW-2:0]};

  // head+TAPS-k is below TAPS when head<k, so modulo-2^AW arithmetic is exact
  assign rd_idx = (head >= k) ? head - k : head + AW'(TAPS) - k;
  assign sample = ring[rd_idx];

`ifdef FIR_TDM_COEF_WR_EN
  logic signed [CW-1:0] coef [TAPS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) coef[i] <= CW'(coef_default(i));
    end else if (bus.coef_we && in_ready && (32'(bus.coef_addr) < TAPS)) begin
      coef[bus.coef_addr] <= bus.coef_wdata;
    end
  end

  assign coef_rd = coef[k];
`else
  assign coef_rd = CW'(coef_default(int'(k)));
`endif

  fir_tdm_mac #(
    .DW   (DW),
    .CW   (CW),
    .ACCW (ACCW)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .en     (busy),
    .sample (sample),
    .coef   (coef_rd),
    .sum    (sum)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head      <= '0;
      k         <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < TAPS; i++) ring[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        head         <= head_new;
        ring[head_new] <= x;
        k            <= '0;
      end else if (busy) begin
        k <= last ? '0 : k + AW'(1);
      end
      if (last) begin
        out_valid <= 1'b1;
        out_data  <= sum;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.busy      = busy;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;

endmodule

// File: tb/tb_fir_tdm_ctrl.sv
// tb/tb_fir_tdm_ctrl.sv - randomized self-checking bench for fir_tdm_ctrl against a convolution model
module tb_fir_tdm_ctrl;

  localparam int TAPS = 16;
  localparam int DW   = 4;
  localparam int CW   = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_tdm_ctrl_if #(.TAPS(TAPS), .DW(DW), .CW(CW)) bus ();

  fir_tdm_ctrl #(.TAPS(TAPS), .DW(DW), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int dflt [16]   = '{-2, -3, -1, 5, 16, 30, 43, 52, 52, 43, 30, 16, 5, -1, -3, -2};
  int mcoef [16];
  int hist [$];

  // y = sum_k coef[k] * x[n-k], newest sample first in hist
  function automatic int model_accept(input int d);
    int s;
    hist.push_front(d - 8);
    if (hist.size() > TAPS) void'(hist.pop_back());
    s = 0;
    for (int i = 0; i < hist.size(); i++) s += mcoef[i] * hist[i];
    return s;
  endfunction

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < TAPS; i++) mcoef[i] = dflt[i];
  endfunction

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
`ifdef FIR_TDM_COEF_WR_EN
    bus.coef_we  = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

`ifdef FIR_TDM_COEF_WR_EN
  task automatic write_coef(input int a, input int v);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = 4'(a);
    bus.coef_wdata = 8'(v);
    @(negedge clk);
    bus.coef_we = 1'b0;
    if (a < TAPS) mcoef[a] = v;
  endtask
`endif

  task automatic wait_result(output bit got, output int res);
    got = 1'b0;
    res = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.out_valid === 1'b1) begin
        got = 1'b1;
        res = $signed(bus.out_data);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic send(input int d, output bit got, output int res);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 4'(d);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_result(got, res);
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'd9;
`ifdef FIR_TDM_COEF_WR_EN
    bus.coef_we  = 1'b0;
`endif
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b, expected 1", bus.in_ready);
    end
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: got %b, expected 0", bus.busy);
    end
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out_valid: got %b, expected 0", bus.out_valid);
    end
    vectors++;
    if (bus.out_data !== '0) begin
      miscompares++;
      $display("FAIL reset_out_data: got %0d, expected 0", $signed(bus.out_data));
    end
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_idle: in_ready=%b busy=%b, expected 1/0", bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_impulse();
    bit got;
    int res, d, exp;
`ifdef FIR_TDM_COEF_WR_EN
    for (int i = 0; i < TAPS; i++) write_coef(i, i + 1);
`endif
    for (int n = 0; n < 17; n++) begin
      d = (n == 0) ? 9 : 8;
      send(d, got, res);
      exp = model_accept(d);
      vectors++;
      if (got !== 1'b1 || res !== exp) begin
        miscompares++;
        $display("FAIL impulse[%0d]: got %0d (valid %b), expected %0d", n, res, got, exp);
      end
    end
  endtask

  task automatic test_dc_max();
    bit got;
    int res, exp;
`ifdef FIR_TDM_COEF_WR_EN
    for (int i = 0; i < TAPS; i++) write_coef(i, 1);
`endif
    for (int n = 0; n < 20; n++) begin
      send(15, got, res);
      exp = model_accept(15);
      vectors++;
      if (got !== 1'b1 || res !== exp) begin
        miscompares++;
        $display("FAIL dc_max[%0d]: got %0d (valid %b), expected %0d", n, res, got, exp);
      end
    end
  endtask

  task automatic test_neg_extreme();
    bit got;
    int res, exp;
`ifdef FIR_TDM_COEF_WR_EN
    for (int i = 0; i < TAPS; i++) write_coef(i, 127);
`endif
    res = 0;
    for (int n = 0; n < 16; n++) begin
      send(0, got, res);
      exp = model_accept(0);
      vectors++;
      if (got !== 1'b1 || res !== exp) begin
        miscompares++;
        $display("FAIL neg_extreme[%0d]: got %0d (valid %b), expected %0d", n, res, got, exp);
      end
    end
`ifdef FIR_TDM_COEF_WR_EN
    vectors++;
    if (res !== -16256) begin
      miscompares++;
      $display("FAIL neg_extreme_final: got %0d, expected -16256", res);
    end
`endif
  endtask

  task automatic test_handshake();
    int acc_c [$];
    int out_c [$];
    int exp_q [$];
    int d, exp, ready_low, busy_bad;
    ready_low = 0;
    busy_bad  = 0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 80; c++) begin
      d = $urandom_range(0, 15);
      bus.in_valid = 1'b1;
      bus.in_data  = 4'(d);
      if (bus.out_valid === 1'b1) begin
        out_c.push_back(c);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h7fff_ffff;
        vectors++;
        if ($signed(bus.out_data) !== exp) begin
          miscompares++;
          $display("FAIL handshake_data[%0d]: got %0d, expected %0d", c, $signed(bus.out_data), exp);
        end
      end
      if (out_c.size() == 3) break;
      if (bus.busy !== ~bus.in_ready) busy_bad++;
      if (bus.in_ready === 1'b1) begin
        acc_c.push_back(c);
        exp_q.push_back(model_accept(d));
      end else begin
        ready_low++;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (out_c.size() != 3 || acc_c.size() != 3) begin
      miscompares++;
      $display("FAIL handshake_count: accepts %0d results %0d, expected 3/3", acc_c.size(), out_c.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (out_c[i] - acc_c[i] != 17) begin
          miscompares++;
          $display("FAIL handshake_latency[%0d]: got %0d, expected 17", i, out_c[i] - acc_c[i]);
        end
        if (i > 0) begin
          vectors++;
          if (acc_c[i] - acc_c[i-1] != 17) begin
            miscompares++;
            $display("FAIL handshake_period[%0d]: got %0d, expected 17", i, acc_c[i] - acc_c[i-1]);
          end
        end
      end
    end
    vectors++;
    if (ready_low != 48 || busy_bad != 0) begin
      miscompares++;
      $display("FAIL handshake_ready_low: got %0d low cycles, %0d busy errors, expected 48/0", ready_low, busy_bad);
    end
  endtask

  task automatic test_reset_mid_mac();
    bit got;
    int res, exp, seen;
    seen = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'($urandom_range(0, 15));
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 25; i++) begin
      if (bus.out_valid === 1'b1) seen++;
      @(negedge clk);
    end
    vectors++;
    if (seen != 0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_mac_abort: got %0d strobes, in_ready %b, expected 0/1", seen, bus.in_ready);
    end
    send(9, got, res);
    exp = model_accept(9);
    vectors++;
    if (got !== 1'b1 || res !== dflt[0] || res !== exp) begin
      miscompares++;
      $display("FAIL reset_mid_mac_result: got %0d (valid %b), expected %0d", res, got, dflt[0]);
    end
  endtask

`ifdef FIR_TDM_COEF_WR_EN
  task automatic test_coef_busy();
    bit got;
    int res, exp, d;
    for (int n = 0; n < 2; n++) begin
      d = $urandom_range(0, 15);
      send(d, got, res);
      exp = model_accept(d);
      vectors++;
      if (got !== 1'b1 || res !== exp) begin
        miscompares++;
        $display("FAIL coef_busy_prefill[%0d]: got %0d (valid %b), expected %0d", n, res, got, exp);
      end
    end
    d = $urandom_range(0, 15);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'(d);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = 4'd0;
    bus.coef_wdata = 8'sd100;
    @(negedge clk);
    bus.coef_we = 1'b0;
    wait_result(got, res);
    exp = model_accept(d);
    vectors++;
    if (got !== 1'b1 || res !== exp) begin
      miscompares++;
      $display("FAIL coef_busy_current: got %0d (valid %b), expected %0d", res, got, exp);
    end
    d = $urandom_range(0, 15);
    send(d, got, res);
    exp = model_accept(d);
    vectors++;
    if (got !== 1'b1 || res !== exp) begin
      miscompares++;
      $display("FAIL coef_busy_next: got %0d (valid %b), expected %0d", res, got, exp);
    end
    d = $urandom_range(0, 15);
    bus.in_valid   = 1'b1;
    bus.in_data    = 4'(d);
    bus.coef_we    = 1'b1;
    bus.coef_addr  = 4'd0;
    bus.coef_wdata = 8'sd100;
    mcoef[0] = 100;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.coef_we  = 1'b0;
    wait_result(got, res);
    exp = model_accept(d);
    vectors++;
    if (got !== 1'b1 || res !== exp) begin
      miscompares++;
      $display("FAIL coef_accept_edge: got %0d (valid %b), expected %0d", res, got, exp);
    end
  endtask
`endif

  task automatic test_random();
    bit got;
    int res, exp, d;
    for (int n = 0; n < 30; n++) begin
`ifdef FIR_TDM_COEF_WR_EN
      if ($urandom_range(0, 3) == 0)
        write_coef($urandom_range(0, TAPS - 1), int'($urandom_range(0, 255)) - 128);
`endif
      repeat ($urandom_range(0, 2)) @(negedge clk);
      d = $urandom_range(0, 15);
      send(d, got, res);
      exp = model_accept(d);
      vectors++;
      if (got !== 1'b1 || res !== exp) begin
        miscompares++;
        $display("FAIL random[%0d]: got %0d (valid %b), expected %0d", n, res, got, exp);
      end
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_impulse();
    test_dc_max();
    test_neg_extreme();
    test_handshake();
    test_reset_mid_mac();
`ifdef FIR_TDM_COEF_WR_EN
    test_coef_busy();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fir_tdm_ctrl.md
# fir_tdm_ctrl

Time-division-multiplexed FIR sequencer. Accepts offset-binary samples, stores them in a circular history buffer, and drives a single shared multiply-accumulate datapath through all taps, one tap per clock. Presents one full-precision signed result per accepted sample. Sits between the waveform/sample source and downstream consumers, and replaces a fully parallel FIR when multiplier area matters.

## Interface
Parameters:
- TAPS, 16, number of taps (≥2; need not be a power of two)
- DW, 4, input sample width (unsigned offset-binary)
- CW, 8, coefficient width (signed two's complement)
- ACCW, DW+CW+$clog2(TAPS), accumulator/output width (derived; do not override)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: synchronous, active-low
- in_valid  in  1  sample offered
- in_ready  out  1  block can accept a sample
- in_data  in  DW  sample, offset-binary
- coef_we  in  1  coefficient write strobe (only with FIR_TDM_COEF_WR_EN)
- coef_addr  in  $clog2(TAPS)  tap index (only with FIR_TDM_COEF_WR_EN)
- coef_wdata  in  CW  coefficient value (only with FIR_TDM_COEF_WR_EN)
- out_valid  out  1  single-cycle result strobe
- out_data  out  ACCW  signed filter result
- busy  out  1  MAC sequence in progress

## Operation
- States: IDLE and MAC. State is IDLE out of reset.
- IDLE: in_ready=1, busy=0. A transfer occurs on an edge where in_valid && in_ready. On that edge:
  - head advances modulo TAPS.
  - x = in_data − 2^(DW−1), a signed DW-bit value, is written to ring[head_new].
  - The accumulator clears, tap index k=0, and the state moves to MAC.
- MAC: in_ready=0, busy=1. Each cycle performs acc += coef[k] * ring[(head − k) mod TAPS], then k++.
  - Product is DW+CW bits signed. Accumulation is full precision in ACCW bits, with no saturation and no rounding.
- On the edge that completes k=TAPS−1: out_data <= final sum, out_valid <= 1 for one cycle, state → IDLE.
- There is no output backpressure. out_data holds its value until the next result.
- Pointer wrap: (head − k) mod TAPS must be computed explicitly for non-power-of-two TAPS.
- Reset: all outputs 0 except in_ready=1 after the reset edge. Ring is cleared to signed 0, head=0, acc=0, coefficients load their defaults. in_valid and coef_we are ignored while rst_n=0.
- Reset mid-MAC aborts the sequence. No out_valid is produced and the history is cleared.

## Timing
- Accept on edge E. MAC occupies the cycles after E through E+TAPS. out_valid is high during the cycle following edge E+TAPS, so latency is TAPS edges.
- in_ready returns to 1 in the same cycle as out_valid. The earliest next accept is edge E+TAPS+1, giving a throughput of 1 sample per TAPS+1 cycles.
- in_ready is a registered-state decode with no combinational path from in_valid.

## Configuration
- FIR_TDM_COEF_WR_EN defined:
  - The coef_we/coef_addr/coef_wdata ports exist and coefficients are held in registers, reset to COEF_DEFAULT.
  - Writes are performed only in IDLE. A write while busy=1 is dropped.
  - A write on the same edge as a sample accept is applied and is used by that sample's MAC sequence.
  - coef_addr ≥ TAPS is ignored.
- Undefined: the coef ports are absent, and coefficients are the constant COEF_DEFAULT from the package.

## Structure
- Package fir_tdm_pkg holds:
  - state enum (IDLE, MAC)
  - COEF_DEFAULT, a 16-entry signed CW-bit low-pass table
  - an ACCW helper function
- Sub-module fir_tdm_mac: signed multiplier plus accumulator with clear/enable controls. The sequencer owns the FSM, ring buffer, pointers and coefficient storage.

## Test plan
Defaults for all scenarios: TAPS=16, DW=4, CW=8, FIR_TDM_COEF_WR_EN defined.
- Impulse: set coef[k]=k+1, then feed 9 followed by fifteen 8s → out_data = 1, 2, …, 16 on successive results; the 17th result is 0.
- DC max: set all coef=1 and feed in_data=15 continuously → results 7, 14, …, 112, then 112 steady.
- Negative extreme: set all coef=127 and feed in_data=0 for 16 samples → final result −16256 with no overflow.
- Handshake: hold in_valid=1 continuously → accepts exactly every 17 cycles, in_ready low for 16 cycles after each accept, out_valid pulses 16 edges after each accept edge.
- Reset mid-MAC: drop rst_n at k=5 → no out_valid. After reset, feed 9 → result = COEF_DEFAULT[0] (history cleared).
- Coefficient write while busy: write coef[0]=100 at k=3 → dropped, and the current and next results are unchanged. Repeating the same write in IDLE on the accept edge takes effect immediately.
